// File: rtl/ktane_bus_master_if.sv
// Host command/response channel and memory-map bus of the KTANE bus master.
// The master modport is the bus master's view; the slave modport is the view
// of whatever sits on the other side (host plus memory map).
interface ktane_bus_master_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [3:0]            cmd_len;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_last;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;
   logic                  we;
   logic [DATA_WIDTH-1:0] q;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, rsp_ready, q,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_last, busy, addr, data, we
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, rsp_ready, q,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_last, busy, addr, data, we
   );
endinterface

// File: rtl/ktane_bus_master.sv
// KTANE bus master: turns single-beat write and incrementing read-burst host
// commands into memory-map cycles against a fixed-latency read port. One read
// beat is in flight at a time; the next address is issued only after the host
// has taken the current word.
module ktane_bus_master #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int READ_LAT   = 1
) (
   input logic clk,
   input logic rst_n,
   ktane_bus_master_if.master bus
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RD_RESP} state_t;

   // RD_WAIT lasts READ_LAT cycles; q is captured on the edge that leaves it.
   localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] wait_cnt;
   logic [3:0] beat_cnt;
   logic [3:0] len_reg;
   logic       last_beat;

   assign last_beat     = (beat_cnt == len_reg);
   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.we        = (state == WRITE);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.cmd_valid) state_nxt = bus.cmd_we ? WRITE : RD_ADDR;
         WRITE:   state_nxt = IDLE;
         RD_ADDR: state_nxt = RD_WAIT;
         RD_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = RD_RESP;
         RD_RESP: if (bus.rsp_ready) state_nxt = last_beat ? IDLE : RD_ADDR;
         default: state_nxt = IDLE;
      endcase
   end

   // Command capture, address sequencing, wait counting and response hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.addr      <= {ADDR_WIDTH{1'b0}};
         bus.data      <= {DATA_WIDTH{1'b0}};
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
         bus.rsp_last  <= 1'b0;
         wait_cnt      <= 2'd0;
         beat_cnt      <= 4'd0;
         len_reg       <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  // addr/data double as the registered copy of the command.
                  bus.addr <= bus.cmd_addr;
                  if (bus.cmd_we) bus.data <= bus.cmd_wdata;
                  len_reg  <= bus.cmd_len;
                  beat_cnt <= 4'd0;
               end
            end
            RD_ADDR: wait_cnt <= 2'd0;
            RD_WAIT: begin
               wait_cnt <= wait_cnt + 2'd1;
               if (wait_cnt == WAIT_LAST) begin
                  bus.rsp_rdata <= bus.q;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_last  <= last_beat;
               end
            end
            RD_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_last  <= 1'b0;
                  if (!last_beat) begin
                     // Wraps naturally at the top of the address space.
                     bus.addr <= bus.addr + ADDR_WIDTH'(1);
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ktane_bus_master.md
KTANE_BUS_MASTER -- requirements
Module: ktane_bus_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the bus data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, the bus address width.
REQ-003 The block SHALL have parameter READ_LAT, default 1, legal range 1..3, the number of clk edges from addr driven to q valid.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  host command present.
REQ-007 cmd_ready  output  1  block accepts a command this cycle.
REQ-008 cmd_we  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  start address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data, single beat.
REQ-011 cmd_len  input  4  read beats minus one (0 = 1 beat, 15 = 16 beats); ignored for writes.
REQ-012 rsp_valid  output  1  read word available.
REQ-013 rsp_ready  input  1  host accepts the read word.
REQ-014 rsp_rdata  output  DATA_WIDTH  read word.
REQ-015 rsp_last  output  1  final beat of a read burst.
REQ-016 busy  output  1  a command is in progress.
REQ-017 addr  output  ADDR_WIDTH  memory-map address.
REQ-018 data  output  DATA_WIDTH  memory-map write data.
REQ-019 we  output  1  memory-map write enable.
REQ-020 q  input  DATA_WIDTH  memory-map read data.

Function
REQ-021 The block SHALL implement the states IDLE, WRITE, RD_ADDR, RD_WAIT, RD_RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-023 Write accepted at edge N: the block SHALL drive addr=cmd_addr, data=cmd_wdata, we=1 for exactly the cycle after edge N, then return to IDLE; cmd_ready SHALL be 1 in the cycle after edge N+1.
REQ-024 we SHALL be 1 only in WRITE, and never for more than one cycle per write command.
REQ-025 Read accepted: RD_ADDR SHALL drive addr=cmd_addr with we=0, and the block SHALL then wait READ_LAT edges in RD_WAIT.
REQ-026 The block SHALL capture q into rsp_rdata on the READ_LAT-th edge after addr is first driven, and SHALL then assert rsp_valid in RD_RESP.
REQ-027 Read latency SHALL be READ_LAT+2 cycles from the accept edge to the first rsp_valid cycle (3 at default).
REQ-028 rsp_valid, rsp_rdata and rsp_last SHALL be held stable until the edge where rsp_valid and rsp_ready are both 1.
REQ-029 After a response handshake with beats remaining, the block SHALL drive addr = previous addr + 1 in the next cycle and repeat the RD_ADDR/RD_WAIT sequence; after the last beat it SHALL return to IDLE.
REQ-030 Address increment SHALL wrap modulo 2^ADDR_WIDTH (16'hFFFF -> 16'h0000).
REQ-031 rsp_last SHALL be 1 only with the beat numbered cmd_len (zero-based).
REQ-032 At most one response SHALL be outstanding; the block SHALL NOT issue the next read address before the current beat's handshake.
REQ-033 addr and data SHALL hold their last driven values in IDLE; we SHALL be 0 in IDLE.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 cmd_addr, cmd_wdata, cmd_we and cmd_len SHALL be registered at accept; input changes after accept SHALL NOT affect the command in progress.
REQ-036 rsp_ready held high continuously SHALL give one beat every READ_LAT+2 cycles.

Reset
REQ-037 With rst_n=0 at an edge, the block SHALL go to IDLE and clear addr=0, data=0, we=0, rsp_valid=0, rsp_rdata=0, rsp_last=0 and busy=0.
REQ-038 cmd_ready SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-039 Reset mid-command SHALL abort the command: no further we pulse, and no remaining beats or pending rsp_valid.

Verification
REQ-040 Write cmd_addr=16'hC000, cmd_wdata=16'h0043 -> exactly one cycle of we=1 with addr=C000, data=0043; cmd_ready returns 2 cycles after accept.
REQ-041 Read cmd_addr=16'h0010, cmd_len=0, with a READ_LAT=1 RAM model holding 16'hBEEF -> rsp_valid 3 cycles after accept, rsp_rdata=BEEF, rsp_last=1.
REQ-042 Read cmd_addr=16'hFFFE, cmd_len=3 -> addresses FFFE, FFFF, 0000, 0001 in order; rsp_last is 1 on the 4th beat only.
REQ-043 Same burst with rsp_ready held low 5 cycles on beat 2 -> rsp_rdata is stable, addr does not advance, and no beat is lost or duplicated.
REQ-044 rst_n=0 during beat 2 of a 16-beat read -> next cycle rsp_valid=0, busy=0, addr=0; cmd_ready=1 after release.
REQ-045 READ_LAT=3 with single-beat reads -> rsp_valid 5 cycles after accept; the captured value matches the model.
